v19_pulse_ctrl: RTL and testbench

//  Sequencer/event scheduler for the v19 trapezoidal shaping filter. It holds the filter in reset

---
 rtl/v19_pulse_ctrl_pkg.sv | 18 +
 rtl/v19_pulse_ctrl.sv | 141 ++++++++++++++
 tb/tb_v19_pulse_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/v19_pulse_ctrl_pkg.sv
// v19 pulse controller shared types and defaults.
// Filter width and controller timing live here.
package v19_pulse_ctrl_pkg;

  localparam int SIZE_FILTER_DATA  = 15;
  localparam int FW_DEF            = SIZE_FILTER_DATA + 1;
  localparam int SETTLE_CYCLES_DEF = 64;
  localparam int DEAD_TIME_DEF     = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ARMED,
    RISE,
    DEAD
  } v19_ctrl_st_t;

endpackage

// File: rtl/v19_pulse_ctrl.sv
// v19 pulse controller: filter reset/settle sequencing, peak
// detection with dead time, one-entry event output register.
module v19_pulse_ctrl
  import v19_pulse_ctrl_pkg::*;
#(
  parameter int FW            = FW_DEF,
  parameter int TS_W          = 16,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DEAD_TIME     = DEAD_TIME_DEF,
  parameter int LOST_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic signed [FW-1:0] threshold,
  input  logic signed [FW-1:0] filt_data,
  output logic                 filt_rst_n,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic signed [FW-1:0] ev_amp,
  output logic [TS_W-1:0]      ev_time,
  output logic                 busy,
  output logic [LOST_W-1:0]    lost_cnt
);

  localparam int CNT_MAX =
    (SETTLE_CYCLES > DEAD_TIME) ? SETTLE_CYCLES : DEAD_TIME;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  v19_ctrl_st_t          st_q, st_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic signed [FW-1:0]  pk_q, pk_d;
  logic [TS_W-1:0]       tc_q, tc_d;
  logic                  frst_q, frst_d;
  logic                  ev_valid_q, ev_valid_d;
  logic signed [FW-1:0]  ev_amp_q, ev_amp_d;
  logic [TS_W-1:0]       ev_time_q, ev_time_d;
  logic [LOST_W-1:0]     lost_q, lost_d;
  logic                  commit;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pk_d   = pk_q;
    tc_d   = tc_q;
    commit = 1'b0;
    if (!enable) begin
      st_d = IDLE;
    end else begin
      unique case (st_q)
        IDLE: begin
          st_d  = SETTLE;
          cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (cnt_q == '0) st_d = ARMED;
          else cnt_d = cnt_q - 1'b1;
        end
        ARMED: begin
          if (filt_data > threshold) begin
            st_d = RISE;
            pk_d = filt_data;
            tc_d = ts_q;
          end
        end
        RISE: begin
          // Equal samples keep the first peak and stay in RISE
          if (filt_data > pk_q) begin
            pk_d = filt_data;
          end else if (filt_data < pk_q) begin
            st_d   = DEAD;
            cnt_d  = CNT_W'(DEAD_TIME - 1);
            commit = 1'b1;
          end
        end
        DEAD: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else if (filt_data <= threshold) st_d = ARMED;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ts_d   = (st_q == IDLE || st_d == IDLE) ? '0 : ts_q + 1'b1;
    frst_d = (st_d != IDLE);
  end

  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_amp_d   = ev_amp_q;
    ev_time_d  = ev_time_q;
    lost_d     = lost_q;
    if (ev_valid_q && ev_ready) ev_valid_d = 1'b0;
    if (commit) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_d = 1'b1;
        ev_amp_d   = pk_q;
        ev_time_d  = tc_q;
      end else if (lost_q != '1) begin
        lost_d = lost_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      ts_q       <= '0;
      pk_q       <= '0;
      tc_q       <= '0;
      frst_q     <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_amp_q   <= '0;
      ev_time_q  <= '0;
      lost_q     <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      ts_q       <= ts_d;
      pk_q       <= pk_d;
      tc_q       <= tc_d;
      frst_q     <= frst_d;
      ev_valid_q <= ev_valid_d;
      ev_amp_q   <= ev_amp_d;
      ev_time_q  <= ev_time_d;
      lost_q     <= lost_d;
    end
  end

  assign filt_rst_n = frst_q;
  assign ev_valid   = ev_valid_q;
  assign ev_amp     = ev_amp_q;
  assign ev_time    = ev_time_q;
  assign lost_cnt   = lost_q;
  assign busy       = (st_q != IDLE) && (st_q != ARMED);

endmodule

// File: tb/tb_v19_pulse_ctrl.sv
// Directed bench for v19_pulse_ctrl: settle, peak events,
// dead-time hysteresis, drops, disable, ts wrap.
module tb_v19_pulse_ctrl;

  localparam int FW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 ev_ready;
  logic signed [FW-1:0] threshold;
  logic signed [FW-1:0] filt_data;
  logic                 filt_rst_n;
  logic                 ev_valid;
  logic signed [FW-1:0] ev_amp;
  logic [15:0]          ev_time;
  logic                 busy;
  logic [7:0]           lost_cnt;

  int n_vec = 0;
  int n_err = 0;
  int ts_exp = 0;
  int tc_exp = 0;
  int tc_a = 0;

  v19_pulse_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .threshold (threshold),
    .filt_data (filt_data),
    .filt_rst_n(filt_rst_n),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_amp    (ev_amp),
    .ev_time   (ev_time),
    .busy      (busy),
    .lost_cnt  (lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ts_exp = (ts_exp + 1) % 65536;
  endtask

  task automatic quiet(input int n);
    filt_data = '0;
    repeat (n) tick();
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    ev_ready  = 1'b0;
    threshold = 16'sd100;
    filt_data = '0;
    #12;
    chk("rst_frst", filt_rst_n, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_amp", ev_amp, 0);
    chk("rst_time", ev_time, 0);
    chk("rst_lost", lost_cnt, 0);
    chk("rst_busy", busy, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_frst", filt_rst_n, 0);

    // settle window, triggers ignored
    enable = 1'b1;
    tick();
    ts_exp = 0;
    chk("en_frst", filt_rst_n, 1);
    chk("en_busy", busy, 1);
    filt_data = 16'sd500;
    repeat (63) tick();
    chk("settle_busy", busy, 1);
    filt_data = '0;
    tick();
    chk("armed64", busy, 0);
    chk("settle_noev", ev_valid, 0);

    // ramp 0,50,120,300,450,400,0
    filt_data = 16'sd0;   tick();
    filt_data = 16'sd50;  tick();
    filt_data = 16'sd120; tc_exp = ts_exp; tick();
    filt_data = 16'sd300; tick();
    filt_data = 16'sd450; tick();
    chk("ramp_lat", ev_valid, 0);
    filt_data = 16'sd400; tick();
    chk("ramp_valid", ev_valid, 1);
    chk("ramp_amp", ev_amp, 450);
    chk("ramp_time", ev_time, 66);
    chk("ramp_tc", ev_time, tc_exp);
    filt_data = '0;
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("ramp_acc", ev_valid, 0);
    quiet(20);
    chk("rearm", busy, 0);

    // hysteresis: data stays above threshold after event
    filt_data = 16'sd300; tick();
    filt_data = 16'sd200; tick();
    chk("hy_valid", ev_valid, 1);
    chk("hy_amp", ev_amp, 300);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    repeat (40) tick();
    chk("hy_dead", busy, 1);
    chk("hy_noev", ev_valid, 0);
    filt_data = 16'sd100; tick();
    chk("hy_arm", busy, 0);
    filt_data = 16'sd150; tick();
    filt_data = 16'sd120; tick();
    chk("hy_ev2", ev_valid, 1);
    chk("hy_amp2", ev_amp, 150);
    filt_data = '0;
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    quiet(20);
    chk("hy_once", ev_valid, 0);

    // back-pressure: second event dropped
    filt_data = 16'sd200; tc_a = ts_exp; tick();
    filt_data = 16'sd300; tick();
    filt_data = 16'sd250; tick();
    quiet(20);
    filt_data = 16'sd150; tick();
    filt_data = 16'sd400; tick();
    filt_data = 16'sd100; tick();
    chk("bp_lost", lost_cnt, 1);
    chk("bp_valid", ev_valid, 1);
    chk("bp_amp", ev_amp, 300);
    chk("bp_time", ev_time, tc_a);
    quiet(20);

    // disable mid-RISE with pending event
    filt_data = 16'sd300; tick();
    filt_data = 16'sd350; tick();
    enable = 1'b0;
    filt_data = 16'sd100; tick();
    chk("dis_frst", filt_rst_n, 0);
    chk("dis_busy", busy, 0);
    chk("dis_valid", ev_valid, 1);
    chk("dis_amp", ev_amp, 300);
    quiet(3);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("dis_acc", ev_valid, 0);
    chk("dis_lost", lost_cnt, 1);

    // re-enable: full settle again
    enable = 1'b1;
    tick();
    ts_exp = 0;
    repeat (63) tick();
    chk("re_settle", busy, 1);
    tick();
    chk("re_armed", busy, 0);

    // saturate lost counter
    repeat (300) begin
      filt_data = 16'sd200; tick();
      filt_data = 16'sd100; tick();
      quiet(17);
    end
    chk("sat_lost", lost_cnt, 255);
    chk("sat_amp", ev_amp, 200);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;

    // ts wrap with accept+commit in same cycle
    filt_data = 16'sd200; tick();
    filt_data = 16'sd110; tick();
    filt_data = '0;
    while (ts_exp != 0) tick();
    filt_data = 16'sd200; tc_exp = ts_exp; tick();
    filt_data = 16'sd250; tick();
    chk("gap_pre", ev_valid, 1);
    chk("gap_old", ev_amp, 200);
    filt_data = 16'sd100;
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("gap_valid", ev_valid, 1);
    chk("wrap_amp", ev_amp, 250);
    chk("wrap_time", ev_time, 0);
    chk("wrap_lost", lost_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
